sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
Shares one SRAM-like bus (req/addr_ok/data_ok split handshake) between the instruction-fetch requester and the data-access requester (MEM-stage loads/stores).
Sits between the pipeline's fetch and memory stages and the single external memory port.
Handles grant sequencing, request holding until address acceptance, anti-starvation, and in-order routing of responses back to the originating requester.

Parameters:
MAX_OUTSTANDING, 2, depth of the response-order FIFO (power of 2, >=2); maximum accepted-but-unanswered transactions
STARVE_LIMIT, 4, consecutive data grants while inst_req is pending before inst is forced a grant

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_req  in  1  fetch read request
inst_size  in  2  0=byte 1=half 2=word
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch read data valid
inst_rdata  out  32  fetch read data
data_req  in  1  data request
data_wr  in  1  1=store 0=load
data_size  in  2  access size
data_addr  in  32  data address
data_wstrb  in  4  byte enables for store
data_wdata  in  32  store data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  load data valid / store complete
data_rdata  out  32  load data
bus_req  out  1  shared bus request
bus_wr  out  1  shared bus write flag
bus_size  out  2  shared bus size
bus_addr  out  32  shared bus address
bus_wstrb  out  4  shared bus byte enables
bus_wdata  out  32  shared bus write data
bus_addr_ok  in  1  bus accepted address
bus_data_ok  in  1  bus response valid
bus_rdata  in  32  bus read data

Behaviour:
- Reset (resetn=0 at clk edge): FSM=IDLE, order FIFO empty (count 0, pointers 0), starve counter 0. All *_ok outputs 0 and bus_req 0 from the following cycle until new requests arrive.
- FSM states: IDLE, HOLD_I, HOLD_D.
- IDLE, FIFO not full: select per the priority rule below. bus_req=1 combinationally in the same cycle.
  - If bus_addr_ok=1 in that cycle: handshake done, stay IDLE.
  - Otherwise: go to HOLD_I or HOLD_D.
- IDLE, FIFO full (count==MAX_OUTSTANDING): no grant, bus_req=0. A same-cycle pop does not bypass full; the full flag comes from the registered count.
- HOLD_x: bus_req=1 and bus fields driven from source x, regardless of the other requester. Leave to IDLE on bus_addr_ok. Requesters must hold req and fields stable until their addr_ok; the arbiter does not check this.
- Priority: data wins over inst, unless starve counter==STARVE_LIMIT and inst_req=1, in which case inst wins.
  - Starve counter increments on each data handshake while inst_req=1.
  - It clears on any inst handshake, or when inst_req=0.
  - It saturates at STARVE_LIMIT.
- Bus field mux:
  - inst grant: bus_wr=0, bus_wstrb=0, bus_wdata=0.
  - data grant: data_* fields passed through unchanged.
  - no grant: all bus fields 0.
- Address handshake (bus_req & bus_addr_ok): push source id (0=inst, 1=data) into the order FIFO. Pulse the granted source's addr_ok combinationally; the other addr_ok stays 0.
- Response: on bus_data_ok, pop the FIFO head and assert inst_data_ok or data_data_ok (whichever the head id names) combinationally in the same cycle. Store completions also produce data_data_ok.
- bus_rdata is forwarded to both inst_rdata and data_rdata unconditionally; it is valid only with the matching data_ok.
- Push and pop in the same cycle: count unchanged, both pointers advance, pointers wrap modulo MAX_OUTSTANDING.
- bus_data_ok with an empty FIFO is a protocol violation: ignored, no *_ok asserted, count stays 0. The bench flags it.
- Pipeline flushes are not visible here. Requesters discard unwanted responses, and the arbiter always returns every accepted transaction.

Decomposition:
- Shared package holds SRC_INST/SRC_DATA id constants and the FSM state encoding (IDLE/HOLD_I/HOLD_D).
- One sub-module: arb_order_fifo (1-bit wide, MAX_OUTSTANDING deep, push/pop/full/empty/head).

Test Plan:
1. Reset mid-HOLD_D with 1 outstanding -> next cycle bus_req=0, count=0; a later bus_data_ok yields no *_ok.
2. inst_req and data_req in the same cycle, bus_addr_ok=1 immediately -> data_addr_ok=1, inst_addr_ok=0, bus_wr/addr equal data's. Inst granted next cycle.
3. data_req held continuously with inst_req=1 -> exactly 4 data grants, then 1 inst grant, then data again.
4. inst load @0x1C000000 then data store @0x100 accepted; bus_data_ok returns twice (rdata 0xDEADBEEF, then x) -> inst_data_ok with rdata 0xDEADBEEF, then data_data_ok.
5. Two accepted transactions with no response -> FIFO full, bus_req=0 despite requests. One bus_data_ok -> grant resumes the next cycle, not the same one.
6. HOLD_I with bus_addr_ok low for 3 cycles while data_req rises -> bus fields stay on inst until accepted; then data is granted.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter.
// Purpose: requester id constants carried through the response-order FIFO,
//          plus the address-phase FSM state encoding.
// Ports:   none (package).
package sram_bus_arbiter_pkg;

  // Requester ids stored in the order FIFO.
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Address-phase FSM: IDLE arbitrates a new request each cycle; HOLD_I and
  // HOLD_D pin the bus to one requester until the bus accepts the address.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_t;

  // Id of the requester that owns a grant (data when data is granted).
  function automatic logic grant_src(input logic grant_data);
    return grant_data ? SRC_DATA : SRC_INST;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_order_fifo.sv
// arb_order_fifo: 1-bit wide, DEPTH deep FIFO recording which requester
// owns each accepted-but-unanswered bus transaction, in acceptance order.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   push, push_id  enqueue a requester id
//   pop            dequeue the head (ignored while empty)
//   head           id at the head of the queue
//   full, empty    status derived from the registered count
module arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on an empty queue is a protocol violation and is dropped.
  // Push is guarded by the registered full flag, so a same-cycle pop never
  // makes room for a push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like split-handshake bus between the
// instruction-fetch and data-access requesters.
// Handshakes: a requester raises *_req with stable fields and holds them until
// its *_addr_ok pulses (address phase complete). Every accepted transaction is
// answered later, in acceptance order, by exactly one *_data_ok pulse.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   inst_req/size/addr                fetch request (read only)
//   inst_addr_ok/data_ok/rdata        fetch handshake results
//   data_req/wr/size/addr/wstrb/wdata data request (load or store)
//   data_addr_ok/data_ok/rdata        data handshake results
//   bus_req/wr/size/addr/wstrb/wdata  shared bus request fields
//   bus_addr_ok/data_ok/rdata         shared bus handshake inputs
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          grant_inst;
  logic          grant_data;
  logic          handshake;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          resp_valid;

  // Inst has waited through STARVE_LIMIT data grants: it takes the next one.
  assign starved = inst_req && (starve_cnt == SW'(STARVE_LIMIT));

  // Grant selection. New grants only start from IDLE with room in the order
  // FIFO; HOLD states keep the current owner regardless of the other side.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full) begin
          if (data_req && !starved) begin
            grant_data = 1'b1;
          end else if (inst_req) begin
            grant_inst = 1'b1;
          end
        end
      end
      HOLD_I:  grant_inst = 1'b1;
      HOLD_D:  grant_data = 1'b1;
      default: begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
      end
    endcase
  end

  // Bus field mux: fetches are always reads with no write payload.
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = 32'd0;
    bus_wstrb = 4'd0;
    bus_wdata = 32'd0;
    if (grant_data) begin
      bus_req   = 1'b1;
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wstrb = data_wstrb;
      bus_wdata = data_wdata;
    end else if (grant_inst) begin
      bus_req   = 1'b1;
      bus_size  = inst_size;
      bus_addr  = inst_addr;
    end
  end

  assign handshake    = bus_req & bus_addr_ok;
  assign inst_addr_ok = grant_inst & bus_addr_ok;
  assign data_addr_ok = grant_data & bus_addr_ok;

  // Responses are steered by the id of the oldest outstanding transaction.
  assign resp_valid   = bus_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_valid & (fifo_head == SRC_INST);
  assign data_data_ok = resp_valid & (fifo_head == SRC_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // Address-phase FSM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data && !bus_addr_ok) begin
            state <= HOLD_D;
          end else if (grant_inst && !bus_addr_ok) begin
            state <= HOLD_I;
          end
        end
        HOLD_I, HOLD_D: begin
          if (bus_addr_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts data handshakes that happened while inst was
  // waiting; any inst handshake or a withdrawn inst_req resets the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || (grant_inst && bus_addr_ok)) begin
      starve_cnt <= '0;
    end else if (grant_data && bus_addr_ok &&
                 (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  arb_order_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (handshake),
    .push_id(grant_src(grant_data)),
    .pop    (bus_data_ok),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed testbench for sram_bus_arbiter with hand-computed expectations.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  sram_bus_arbiter #(
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT   (4)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_size   (inst_size),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wstrb  (data_wstrb),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    inst_req    = 1'b0;
    inst_size   = 2'd0;
    inst_addr   = 32'd0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'd0;
    data_wstrb  = 4'd0;
    data_wdata  = 32'd0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'd0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well clear of either edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_req  = req;
    inst_size = 2'd2;
    inst_addr = addr;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wdata);
    data_req   = req;
    data_wr    = wr;
    data_size  = 2'd2;
    data_addr  = addr;
    data_wstrb = strb;
    data_wdata = wdata;
  endtask

  initial begin
    logic exp_d [6];
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    clear_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    settle();
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_data_data_ok", data_data_ok, 0);

    // 1: reset while holding a data request with one transaction outstanding
    step();
    set_data(1, 0, 32'h200, 4'h0, 32'h0);
    bus_addr_ok = 1'b1;
    settle();
    check("t1_accept", data_addr_ok, 1);
    step();
    set_data(1, 0, 32'h204, 4'h0, 32'h0);
    bus_addr_ok = 1'b0;
    settle();
    check("t1_hold_req", bus_req, 1);
    check("t1_hold_addr", bus_addr, 32'h204);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    clear_inputs();
    settle();
    check("t1_after_rst_req", bus_req, 0);
    step();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h1111_1111;
    settle();
    check("t1_stray_inst_ok", inst_data_ok, 0);
    check("t1_stray_data_ok", data_data_ok, 0);

    // 2: simultaneous requests, data wins, inst follows
    step();
    clear_inputs();
    set_inst(1, 32'h1C00_0000);
    set_data(1, 1, 32'h300, 4'hF, 32'h1234_5678);
    bus_addr_ok = 1'b1;
    settle();
    check("t2_data_addr_ok", data_addr_ok, 1);
    check("t2_inst_addr_ok", inst_addr_ok, 0);
    check("t2_bus_wr", bus_wr, 1);
    check("t2_bus_addr", bus_addr, 32'h300);
    check("t2_bus_wstrb", bus_wstrb, 4'hF);
    check("t2_bus_wdata", bus_wdata, 32'h1234_5678);
    step();
    set_data(0, 0, 32'h0, 4'h0, 32'h0);
    settle();
    check("t2_inst_addr_ok2", inst_addr_ok, 1);
    check("t2_bus_addr2", bus_addr, 32'h1C00_0000);
    check("t2_bus_wr2", bus_wr, 0);
    check("t2_bus_wstrb2", bus_wstrb, 0);
    step();
    clear_inputs();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hAAAA_0000;
    settle();
    check("t2_resp1_data", data_data_ok, 1);
    check("t2_resp1_inst", inst_data_ok, 0);
    step();
    bus_rdata = 32'h0000_5555;
    settle();
    check("t2_resp2_inst", inst_data_ok, 1);
    check("t2_resp2_data", data_data_ok, 0);
    check("t2_resp2_rdata", inst_rdata, 32'h0000_5555);

    // 3: data held with inst pending: D D D D I D; responses trail grants
    for (int k = 0; k < 6; k++) begin
      step();
      clear_inputs();
      set_inst(1, 32'h1C00_0010);
      set_data(1, 0, 32'h600, 4'h0, 32'h0);
      bus_addr_ok = 1'b1;
      bus_data_ok = (k != 0);
      settle();
      check($sformatf("t3_data_grant_%0d", k), data_addr_ok, exp_d[k]);
      check($sformatf("t3_inst_grant_%0d", k), inst_addr_ok, !exp_d[k]);
      if (k != 0) begin
        check($sformatf("t3_resp_%0d", k), data_data_ok, exp_d[k-1]);
      end
    end
    step();
    clear_inputs();
    bus_data_ok = 1'b1;
    settle();
    check("t3_drain", data_data_ok, 1);

    // 4: inst load then data store, responses in order
    step();
    clear_inputs();
    set_inst(1, 32'h1C00_0000);
    bus_addr_ok = 1'b1;
    settle();
    check("t4_inst_accept", inst_addr_ok, 1);
    step();
    set_inst(0, 32'h0);
    set_data(1, 1, 32'h100, 4'h3, 32'h0000_CAFE);
    settle();
    check("t4_data_accept", data_addr_ok, 1);
    check("t4_bus_wstrb", bus_wstrb, 4'h3);
    step();
    clear_inputs();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hDEAD_BEEF;
    settle();
    check("t4_inst_data_ok", inst_data_ok, 1);
    check("t4_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    check("t4_data_quiet", data_data_ok, 0);
    step();
    bus_rdata = 32'h0;
    settle();
    check("t4_data_data_ok", data_data_ok, 1);
    check("t4_inst_quiet", inst_data_ok, 0);

    // 5: FIFO full blocks grants; a pop frees a slot only from the next cycle
    step();
    clear_inputs();
    set_data(1, 0, 32'h400, 4'h0, 32'h0);
    bus_addr_ok = 1'b1;
    settle();
    check("t5_accept1", data_addr_ok, 1);
    step();
    settle();
    check("t5_accept2", data_addr_ok, 1);
    step();
    settle();
    check("t5_full_req", bus_req, 0);
    check("t5_full_ok", data_addr_ok, 0);
    check("t5_full_addr", bus_addr, 0);
    step();
    bus_data_ok = 1'b1;
    settle();
    check("t5_pop_resp", data_data_ok, 1);
    check("t5_no_bypass", bus_req, 0);
    step();
    bus_data_ok = 1'b0;
    settle();
    check("t5_resume", data_addr_ok, 1);
    step();
    clear_inputs();
    bus_data_ok = 1'b1;
    settle();
    check("t5_drain1", data_data_ok, 1);
    step();
    settle();
    check("t5_drain2", data_data_ok, 1);

    // 6: HOLD_I stays on inst while data arrives
    step();
    clear_inputs();
    set_inst(1, 32'h1C00_0040);
    settle();
    check("t6_req", bus_req, 1);
    check("t6_addr0", bus_addr, 32'h1C00_0040);
    for (int k = 1; k < 3; k++) begin
      step();
      set_data(1, 1, 32'h500, 4'hF, 32'h5A5A_5A5A);
      settle();
      check($sformatf("t6_hold_addr_%0d", k), bus_addr, 32'h1C00_0040);
      check($sformatf("t6_hold_wr_%0d", k), bus_wr, 0);
    end
    step();
    bus_addr_ok = 1'b1;
    settle();
    check("t6_inst_accept", inst_addr_ok, 1);
    check("t6_data_wait", data_addr_ok, 0);
    step();
    set_inst(0, 32'h0);
    settle();
    check("t6_data_accept", data_addr_ok, 1);
    check("t6_data_addr", bus_addr, 32'h500);
    step();
    clear_inputs();
    bus_data_ok = 1'b1;
    settle();
    check("t6_resp_inst", inst_data_ok, 1);
    step();
    settle();
    check("t6_resp_data", data_data_ok, 1);
    step();
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
